// File: rtl/sha256_msg_padder_if.sv
// Memory read port and padded-word stream of the SHA-256 message padder.
// master = padder side, slave = memory + hash core side.
interface sha256_msg_padder_if;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_read_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_idx;
  logic        blk_last;

  modport master (
    output mem_addr, mem_re,
    output w_valid, w_data, w_idx, blk_last,
    input  mem_read_data, w_ready
  );

  modport slave (
    input  mem_addr, mem_re,
    input  w_valid, w_data, w_idx, blk_last,
    output mem_read_data, w_ready
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// Streams a NUM_OF_WORDS-word message from memory as SHA-256 padded
// 512-bit blocks: data, 0x80000000, zero fill, 64-bit bit length.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        busy,
  output logic        done,
  sha256_msg_padder_if.master bus
);

  localparam int NB    = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam int TOTAL = 16 * NB;

  localparam logic [15:0] N_W    = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LAST_G = 16'(TOTAL - 1);
  localparam logic [15:0] BLK0_G = 16'(TOTAL - 16);
  localparam logic [31:0] LEN_W  = 32'(NUM_OF_WORDS) << 5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] g_q, g_d;
  logic [15:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;

  logic        rd_hit;
  logic [31:0] pad_w;

  assign rd_hit = (state_q == S_RD) && (g_q < N_W);

  // Length high word is always zero, so only two pad words are non-zero
  always_comb begin
    pad_w = 32'h0;
    if (g_q == N_W)
      pad_w = 32'h8000_0000;
    else if (g_q == LAST_G)
      pad_w = LEN_W;
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = message_addr;
          g_d     = 16'd0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (rd_hit) begin
          state_d = S_CAP;
        end else begin
          wdata_d = pad_w;
          state_d = S_OUT;
        end
      end
      S_CAP: begin
        wdata_d = bus.mem_read_data;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.w_ready) begin
          if (g_q == LAST_G) begin
            state_d = S_FIN;
          end else begin
            g_d     = g_q + 16'd1;
            state_d = S_RD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      g_q     <= 16'd0;
      base_q  <= 16'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.mem_re   = rd_hit;
  assign bus.mem_addr = rd_hit ? (base_q + g_q) : 16'd0;
  assign bus.w_valid  = (state_q == S_OUT);
  assign bus.w_data   = wdata_q;
  assign bus.w_idx    = g_q[3:0];
  assign bus.blk_last = bus.w_valid && (g_q >= BLK0_G);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench: two padders (20 and 13 words) share one memory;
// expected words come from the padding rules, checked by monitors.
module tb_sha256_msg_padder;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  i;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] msg_addr = 16'h0;
  logic        busy_a, done_a, busy_b, done_b;

  sha256_msg_padder_if ba ();
  sha256_msg_padder_if bb ();

  sha256_msg_padder #(.NUM_OF_WORDS(20)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .message_addr(msg_addr), .busy(busy_a), .done(done_a),
    .bus(ba.master)
  );

  sha256_msg_padder #(.NUM_OF_WORDS(13)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .message_addr(msg_addr), .busy(busy_b), .done(done_b),
    .bus(bb.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];

  always @(posedge clk) begin
    if (ba.mem_re) ba.mem_read_data <= mem[ba.mem_addr];
    if (bb.mem_re) bb.mem_read_data <= mem[bb.mem_addr];
  end

  // 0: always ready, 1: random, 2: A held off (B ready)
  int mode = 0;
  initial begin
    ba.w_ready = 1'b0;
    bb.w_ready = 1'b0;
    ba.mem_read_data = 32'h0;
    bb.mem_read_data = 32'h0;
  end
  always @(posedge clk) begin
    #1;
    case (mode)
      0: begin ba.w_ready = 1'b1; bb.w_ready = 1'b1; end
      1: begin
        ba.w_ready = ($urandom_range(0, 3) != 0);
        bb.w_ready = ($urandom_range(0, 3) != 0);
      end
      default: begin ba.w_ready = 1'b0; bb.w_ready = 1'b1; end
    endcase
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    total_cnt++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  exp_t        qa[$], qb[$];
  logic [15:0] ra[$], rb[$];
  int rd_cnt_a = 0, rd_cnt_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int dexp_a = 0, dexp_b = 0;
  bit hs_a = 0, hs_b = 0;

  // Padding rules straight from the message-length arithmetic
  function automatic exp_t ref_word(input int n, input int g,
                                    input logic [15:0] a);
    exp_t e;
    int nb, t;
    logic [15:0] ad;
    nb = (n + 3 + 15) / 16;
    t  = 16 * nb;
    ad = a + 16'(g);
    if (g < n)          e.d = mem[ad];
    else if (g == n)    e.d = 32'h8000_0000;
    else if (g == t - 1) e.d = 32'(n * 32);
    else                e.d = 32'h0;
    e.i = 4'(g % 16);
    e.l = ((g / 16) == nb - 1);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      hs_a = 0;
      hs_b = 0;
    end else begin
      if (ba.mem_re) begin
        rd_cnt_a++;
        if (ra.size() == 0) fail("rd_extra_a");
        else chk("rd_addr_a", 32'(ba.mem_addr), 32'(ra.pop_front()));
      end
      if (bb.mem_re) begin
        rd_cnt_b++;
        if (rb.size() == 0) fail("rd_extra_b");
        else chk("rd_addr_b", 32'(bb.mem_addr), 32'(rb.pop_front()));
      end
      if (hs_a) chk("gap_a", 32'(ba.w_valid), 32'd0);
      if (hs_b) chk("gap_b", 32'(bb.w_valid), 32'd0);
      if (ba.w_valid) begin
        if (qa.size() == 0) fail("w_extra_a");
        else begin
          chk("data_a", ba.w_data, qa[0].d);
          chk("idx_a", 32'(ba.w_idx), 32'(qa[0].i));
          chk("last_a", 32'(ba.blk_last), 32'(qa[0].l));
          if (ba.w_ready) void'(qa.pop_front());
        end
      end
      if (bb.w_valid) begin
        if (qb.size() == 0) fail("w_extra_b");
        else begin
          chk("data_b", bb.w_data, qb[0].d);
          chk("idx_b", 32'(bb.w_idx), 32'(qb[0].i));
          chk("last_b", 32'(bb.blk_last), 32'(qb[0].l));
          if (bb.w_ready) void'(qb.pop_front());
        end
      end
      hs_a = ba.w_valid && ba.w_ready;
      hs_b = bb.w_valid && bb.w_ready;
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
    end
  end

  int snap_a, snap_b;

  task automatic launch(input logic [15:0] a, input bit use_b,
                        input bit seq);
    logic [15:0] ad;
    for (int i = 0; i < 20; i++) begin
      ad = a + 16'(i);
      mem[ad] = seq ? 32'(i + 1) : $urandom;
    end
    for (int g = 0; g < 32; g++) qa.push_back(ref_word(20, g, a));
    for (int g = 0; g < 20; g++) ra.push_back(a + 16'(g));
    if (use_b) begin
      for (int g = 0; g < 16; g++) qb.push_back(ref_word(13, g, a));
      for (int g = 0; g < 13; g++) rb.push_back(a + 16'(g));
    end
    snap_a = rd_cnt_a;
    snap_b = rd_cnt_b;
    @(posedge clk);
    #1;
    msg_addr = a;
    start_a = 1'b1;
    start_b = use_b;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic finish_msg(input bit use_b);
    bit ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy_a && !busy_b && qa.size() == 0 && qb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      fail("timeout_msg");
      qa.delete(); qb.delete(); ra.delete(); rb.delete();
    end
    dexp_a++;
    if (use_b) dexp_b++;
    chk("done_cnt_a", 32'(done_cnt_a), 32'(dexp_a));
    chk("done_cnt_b", 32'(done_cnt_b), 32'(dexp_b));
    chk("nreads_a", 32'(rd_cnt_a - snap_a), 32'd20);
    if (use_b) chk("nreads_b", 32'(rd_cnt_b - snap_b), 32'd13);
  endtask

  task automatic wait_ev(input logic [3:0] idx, input logic last);
    bit ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (ba.w_valid && ba.w_idx == idx && ba.blk_last == last) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail("timeout_word");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
    chk({tag, "_done_a"}, 32'(done_a), 32'd0);
    chk({tag, "_wvalid_a"}, 32'(ba.w_valid), 32'd0);
    chk({tag, "_re_a"}, 32'(ba.mem_re), 32'd0);
    chk({tag, "_addr_a"}, 32'(ba.mem_addr), 32'd0);
    chk({tag, "_wdata_a"}, ba.w_data, 32'd0);
    chk({tag, "_widx_a"}, 32'(ba.w_idx), 32'd0);
    chk({tag, "_last_a"}, 32'(ba.blk_last), 32'd0);
    chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
    chk({tag, "_wvalid_b"}, 32'(bb.w_valid), 32'd0);
    chk({tag, "_re_b"}, 32'(bb.mem_re), 32'd0);
    chk({tag, "_wdata_b"}, bb.w_data, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Sequential content, always ready, both lengths
    launch(16'h0010, 1, 1);
    finish_msg(1);

    // Downstream stall on word 5
    launch(16'h0010, 0, 1);
    wait_ev(4'd4, 1'b0);
    mode = 2;
    wait_ev(4'd5, 1'b0);
    snap_b = rd_cnt_a;
    repeat (10) @(negedge clk);
    chk("stall_reads", 32'(rd_cnt_a - snap_b), 32'd0);
    chk("stall_idx", 32'(ba.w_idx), 32'd5);
    mode = 0;
    finish_msg(0);

    // Start while busy must be ignored
    launch(16'h0010, 0, 1);
    wait_ev(4'd7, 1'b0);
    msg_addr = 16'h3000;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    finish_msg(0);

    // Address wrap, random backpressure
    mode = 1;
    launch(16'hFFFE, 1, 0);
    finish_msg(1);

    // Reset mid-message at g=18
    launch(16'($urandom), 0, 0);
    wait_ev(4'd2, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    qa.delete(); qb.delete(); ra.delete(); rb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    launch(16'($urandom), 1, 0);
    finish_msg(1);

    for (int k = 0; k < 4; k++) begin
      launch(16'($urandom), k[0], 0);
      finish_msg(k[0]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
